// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the raw lines, deframes 11-bit
// frames and folds E0/F0 prefixes into flags. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_scan_receiver #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       data,
   output logic [7:0] code,
   output logic       key_valid,
   output logic       released,
   output logic       extended,
   output logic       frame_err
);

   // state  | meaning
   // IDLE   | waiting for a start bit (sampled 0)
   // DATA   | shifting in 8 data bits, LSB first
   // PARITY | capturing the parity bit
   // STOP   | validating the frame on the stop-bit fall
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_f, fall;
   logic [FW-1:0] flt_cnt;

   state_t        state;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          break_pending, ext_pending;
   logic [TW-1:0] tcnt;
   logic          frame_ok;
`ifdef PS2_PARITY_CHECK_EN
   logic          par_bit;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         dat_s1  <= 1'b1;
         dat_s2  <= 1'b1;
         clk_f   <= 1'b1;
         flt_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= data;
         dat_s2 <= dat_s1;
         fall   <= 1'b0;
         // flt_cnt counts consecutive samples disagreeing with the filtered level
         if (clk_s2 == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_f   <= clk_s2;
            flt_cnt <= '0;
            fall    <= clk_f;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      frame_ok = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      frame_ok = dat_s2 & (^{shift_reg, par_bit});
`else
      frame_ok = dat_s2;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bit_idx       <= '0;
         shift_reg     <= '0;
         break_pending <= 1'b0;
         ext_pending   <= 1'b0;
         tcnt          <= '0;
         code          <= '0;
         key_valid     <= 1'b0;
         released      <= 1'b0;
         extended      <= 1'b0;
         frame_err     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_bit       <= 1'b0;
`endif
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            tcnt <= '0;
            case (state)
               IDLE: begin
                  if (!dat_s2) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end
               end
               DATA: begin
                  shift_reg <= {dat_s2, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= PARITY;
               end
               PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  par_bit <= dat_s2;
`endif
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!frame_ok) begin
                     frame_err     <= 1'b1;
                     break_pending <= 1'b0;
                     ext_pending   <= 1'b0;
                  end else if (shift_reg == 8'hF0) begin
                     break_pending <= 1'b1;
                  end else if (shift_reg == 8'hE0) begin
                     ext_pending <= 1'b1;
                  end else begin
                     code          <= shift_reg;
                     released      <= break_pending;
                     extended      <= ext_pending;
                     key_valid     <= 1'b1;
                     break_pending <= 1'b0;
                     ext_pending   <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               frame_err     <= 1'b1;
               state         <= IDLE;
               break_pending <= 1'b0;
               ext_pending   <= 1'b0;
               tcnt          <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end else begin
            tcnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: frames, prefixes, parity/stop errors, timeout, glitches, reset.
module tb_ps2_scan_receiver;

   localparam int FLT = 4;
   localparam int TMO = 300;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       data = 1'b1;
   logic [7:0] code;
   logic       key_valid, released, extended, frame_err;

   int n_vec = 0;
   int n_err = 0;
   int kv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;

   ps2_scan_receiver #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .data(data),
      .code(code), .key_valid(key_valid), .released(released),
      .extended(extended), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_valid) kv_cnt++;
      if (frame_err) fe_cnt++;
      if (key_valid && frame_err) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives the first nfall bits of {stop, parity, byte, start}; glitch adds 1-cycle pulses.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                             input logic glitch, input int nfall);
      logic [10:0] frm;
      frm = {stp, par, b, 1'b0};
      for (int i = 0; i < nfall; i++) begin
         @(negedge clk);
         data = frm[i];
         wait_cyc(5);
         if (glitch) begin ps2_clk = 1'b0; @(negedge clk); ps2_clk = 1'b1; end
         wait_cyc(6);
         ps2_clk = 1'b0;
         wait_cyc(10);
         if (glitch) begin ps2_clk = 1'b1; @(negedge clk); ps2_clk = 1'b0; end
         wait_cyc(14);
         ps2_clk = 1'b1;
         wait_cyc(13);
      end
      data = 1'b1;
      wait_cyc(20);
   endtask

   task automatic frame_chk(input string tag, input int kv0, input int fe0, input int ekv,
                            input int efe, input logic [7:0] ec, input logic er, input logic ee);
      chk({tag, " key_valid cycles"}, 32'(kv_cnt - kv0), 32'(ekv));
      chk({tag, " frame_err cycles"}, 32'(fe_cnt - fe0), 32'(efe));
      chk({tag, " code"}, 32'(code), 32'(ec));
      chk({tag, " released"}, 32'(released), 32'(er));
      chk({tag, " extended"}, 32'(extended), 32'(ee));
   endtask

   initial begin
      int kv0, fe0, n;
      logic [10:0] frm;

      wait_cyc(3);
      chk("reset code", 32'(code), 32'h00);
      chk("reset flags", 32'({key_valid, released, extended, frame_err}), 32'h0);
      rst = 1'b0;
      wait_cyc(10);

      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'h1D, 1'b1, 1'b1, 1'b0, 11);
      frame_chk("1D", kv0, fe0, 1, 0, 8'h1D, 1'b0, 1'b0);

      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 11);
      frame_chk("F0 prefix", kv0, fe0, 0, 0, 8'h1D, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
      frame_chk("F0 1C", kv0, fe0, 1, 0, 8'h1C, 1'b1, 1'b0);
      kv0 = kv_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
      frame_chk("1C make", kv0, fe0, 1, 0, 8'h1C, 1'b0, 1'b0);

      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 11);
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 11);
      send_frame(8'h75, 1'b0, 1'b1, 1'b0, 11);
      frame_chk("E0 F0 75", kv0, fe0, 1, 0, 8'h75, 1'b1, 1'b1);

      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'h23, 1'b1, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
      frame_chk("23 bad parity", kv0, fe0, 0, 1, 8'h75, 1'b1, 1'b1);
`else
      frame_chk("23 parity ignored", kv0, fe0, 1, 0, 8'h23, 1'b0, 1'b0);
`endif

      // Timeout: start + 4 data bits, then a 6th fall measured against frame_err.
      fe0 = fe_cnt; kv0 = kv_cnt;
      send_frame(8'h1D, 1'b1, 1'b1, 1'b0, 5);
      frm = {1'b1, 1'b1, 8'h1D, 1'b0};
      @(negedge clk);
      data = frm[5];
      wait_cyc(12);
      ps2_clk = 1'b0;
      n = 0;
      while (n < TMO + 50) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 25) ps2_clk = 1'b1;
         if (frame_err) break;
      end
      chk("timeout latency", 32'(n), 32'(TMO + 7));
      data = 1'b1;
      wait_cyc(20);
      chk("timeout frame_err cycles", 32'(fe_cnt - fe0), 32'd1);
      chk("timeout key_valid cycles", 32'(kv_cnt - kv0), 32'd0);
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'h1B, 1'b1, 1'b1, 1'b0, 11);
      frame_chk("1B after timeout", kv0, fe0, 1, 0, 8'h1B, 1'b0, 1'b0);

      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'h1D, 1'b1, 1'b1, 1'b1, 11);
      frame_chk("1D glitched", kv0, fe0, 1, 0, 8'h1D, 1'b0, 1'b0);

      // Bad stop bit after an F0 prefix: error clears the prefix.
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 11);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11);
      frame_chk("bad stop", kv0, fe0, 0, 1, 8'h1D, 1'b0, 1'b0);
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
      frame_chk("1C after error", kv0, fe0, 1, 0, 8'h1C, 1'b0, 1'b0);

      // Reset mid-frame following an E0 prefix.
      send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 11);
      send_frame(8'h1D, 1'b1, 1'b1, 1'b0, 3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid rst code", 32'(code), 32'h00);
      chk("mid rst flags", 32'({key_valid, released, extended, frame_err}), 32'h0);
      data = 1'b1;
      wait_cyc(20);
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'h1D, 1'b1, 1'b1, 1'b0, 11);
      frame_chk("1D after rst", kv0, fe0, 1, 0, 8'h1D, 1'b0, 1'b0);

      chk("key_valid with frame_err", 32'(both_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
